// File: rtl/mbtrain_partner_responder_pkg.sv
// Sideband message codes shared by the MBTRAIN responder and its sideband interface.
package mbtrain_partner_responder_pkg;

  typedef enum logic [7:0] {
    SB_NOP                        = 8'h00,
    MBTRAIN_VALVREF_start_req     = 8'h01,
    MBTRAIN_VALVREF_start_resp    = 8'h02,
    MBTRAIN_VALVREF_end_req       = 8'h03,
    MBTRAIN_VALVREF_end_resp      = 8'h04,
    MBTRAIN_DATAVREF_start_req    = 8'h05,
    MBTRAIN_DATAVREF_start_resp   = 8'h06,
    MBTRAIN_DATAVREF_end_req      = 8'h07,
    MBTRAIN_DATAVREF_end_resp     = 8'h08,
    MBTRAIN_SPEEDIDLE_start_req   = 8'h09,
    MBTRAIN_SPEEDIDLE_start_resp  = 8'h0a,
    MBTRAIN_SPEEDIDLE_end_req     = 8'h0b,
    MBTRAIN_SPEEDIDLE_end_resp    = 8'h0c,
    MBTRAIN_TXSELFCAL_start_req   = 8'h0d,
    MBTRAIN_TXSELFCAL_start_resp  = 8'h0e,
    MBTRAIN_TXSELFCAL_end_req     = 8'h0f,
    MBTRAIN_TXSELFCAL_end_resp    = 8'h10,
    MBTRAIN_RXCLKCAL_start_req    = 8'h11,
    MBTRAIN_RXCLKCAL_start_resp   = 8'h12,
    MBTRAIN_RXCLKCAL_end_req      = 8'h13,
    MBTRAIN_RXCLKCAL_end_resp     = 8'h14,
    MBTRAIN_LINKSPEED_start_req   = 8'h15,
    MBTRAIN_LINKSPEED_start_resp  = 8'h16,
    MBTRAIN_LINKSPEED_end_req     = 8'h17,
    MBTRAIN_LINKSPEED_end_resp    = 8'h18
  } SB_msg_t;

endpackage

// File: rtl/mbtrain_partner_responder_if.sv
// Sideband RX/TX channel bundle between the link partner side (master) and the responder (slave).
interface mbtrain_partner_responder_if;
  import mbtrain_partner_responder_pkg::*;

  SB_msg_t     SB_RX_msg_i;
  logic [63:0] SB_RX_dataBus_i;
  logic        SB_RX_msg_valid_i;
  logic        SB_RX_msg_req_o;
  SB_msg_t     SB_TX_msg_o;
  logic [63:0] SB_TX_dataBus_o;
  logic        SB_TX_msg_valid_o;
  logic        SB_TX_msg_sendNextFlag_i;

  modport master (
    output SB_RX_msg_i, SB_RX_dataBus_i, SB_RX_msg_valid_i, SB_TX_msg_sendNextFlag_i,
    input  SB_RX_msg_req_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o
  );

  modport slave (
    input  SB_RX_msg_i, SB_RX_dataBus_i, SB_RX_msg_valid_i, SB_TX_msg_sendNextFlag_i,
    output SB_RX_msg_req_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o
  );

endinterface

// File: rtl/mbtrain_partner_responder.sv
// MBTRAIN sideband responder: answers the partner's start/end requests for the six substates
// in fixed order, with a per-message timeout and sticky error reporting.
module mbtrain_partner_responder
  import mbtrain_partner_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic                              clk_100MHz,
  input  logic                              reset,
  input  logic                              enable_i,
  mbtrain_partner_responder_if.slave        sb,
  output logic [2:0]                        substate_o,
  output logic                              done_o,
  output logic                              error_o,
  output logic                              timeout_o
);

  typedef enum logic [2:0] {StIdle, StWaitReq, StSendResp, StDone, StError} state_e;

  localparam logic [19:0] CntLast = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LastSub = 3'd5;

  state_e      state_q;
  logic [2:0]  substate_q;
  logic        phase_q;
  logic [19:0] cnt_q;
  logic        req_q;
  logic        valid_q;
  SB_msg_t     tx_msg_q;
  logic [63:0] tx_data_q;
  logic        done_q;
  logic        error_q;
  logic        timeout_q;

  SB_msg_t     exp_req;
  SB_msg_t     exp_resp;

  // Request expected next and the response that answers it, from (substate, phase).
  always_comb begin
    exp_req  = SB_NOP;
    exp_resp = SB_NOP;
    case (substate_q)
      3'd0: begin
        exp_req  = phase_q ? MBTRAIN_VALVREF_end_req  : MBTRAIN_VALVREF_start_req;
        exp_resp = phase_q ? MBTRAIN_VALVREF_end_resp : MBTRAIN_VALVREF_start_resp;
      end
      3'd1: begin
        exp_req  = phase_q ? MBTRAIN_DATAVREF_end_req  : MBTRAIN_DATAVREF_start_req;
        exp_resp = phase_q ? MBTRAIN_DATAVREF_end_resp : MBTRAIN_DATAVREF_start_resp;
      end
      3'd2: begin
        exp_req  = phase_q ? MBTRAIN_SPEEDIDLE_end_req  : MBTRAIN_SPEEDIDLE_start_req;
        exp_resp = phase_q ? MBTRAIN_SPEEDIDLE_end_resp : MBTRAIN_SPEEDIDLE_start_resp;
      end
      3'd3: begin
        exp_req  = phase_q ? MBTRAIN_TXSELFCAL_end_req  : MBTRAIN_TXSELFCAL_start_req;
        exp_resp = phase_q ? MBTRAIN_TXSELFCAL_end_resp : MBTRAIN_TXSELFCAL_start_resp;
      end
      3'd4: begin
        exp_req  = phase_q ? MBTRAIN_RXCLKCAL_end_req  : MBTRAIN_RXCLKCAL_start_req;
        exp_resp = phase_q ? MBTRAIN_RXCLKCAL_end_resp : MBTRAIN_RXCLKCAL_start_resp;
      end
      3'd5: begin
        exp_req  = phase_q ? MBTRAIN_LINKSPEED_end_req  : MBTRAIN_LINKSPEED_start_req;
        exp_resp = phase_q ? MBTRAIN_LINKSPEED_end_resp : MBTRAIN_LINKSPEED_start_resp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset || !enable_i) begin
      state_q    <= StIdle;
      substate_q <= '0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      tx_msg_q   <= SB_NOP;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StWaitReq;
          req_q   <= 1'b1;
          cnt_q   <= '0;
        end

        StWaitReq: begin
          if (req_q && sb.SB_RX_msg_valid_i) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (sb.SB_RX_msg_i == exp_req) begin
              state_q  <= StSendResp;
              valid_q  <= 1'b1;
              tx_msg_q <= exp_resp;
              // Only the LINKSPEED end_resp echoes the partner's payload.
              tx_data_q <= (substate_q == LastSub && phase_q) ? sb.SB_RX_dataBus_i : '0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end else if (cnt_q == CntLast) begin
            state_q   <= StError;
            req_q     <= 1'b0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        StSendResp: begin
          if (sb.SB_TX_msg_sendNextFlag_i) begin
            valid_q   <= 1'b0;
            tx_msg_q  <= SB_NOP;
            tx_data_q <= '0;
            cnt_q     <= '0;
            if (!phase_q) begin
              phase_q <= 1'b1;
              req_q   <= 1'b1;
              state_q <= StWaitReq;
            end else if (substate_q != LastSub) begin
              substate_q <= substate_q + 3'd1;
              phase_q    <= 1'b0;
              req_q      <= 1'b1;
              state_q    <= StWaitReq;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end else if (cnt_q == CntLast) begin
            state_q   <= StError;
            valid_q   <= 1'b0;
            tx_msg_q  <= SB_NOP;
            tx_data_q <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        // DONE and ERROR hold until enable_i drops.
        default: ;
      endcase
    end
  end

  assign sb.SB_RX_msg_req_o   = req_q;
  assign sb.SB_TX_msg_valid_o = valid_q;
  assign sb.SB_TX_msg_o       = tx_msg_q;
  assign sb.SB_TX_dataBus_o   = tx_data_q;
  assign substate_o           = substate_q;
  assign done_o               = done_q;
  assign error_o              = error_q;
  assign timeout_o            = timeout_q;

endmodule

// File: doc/mbtrain_partner_responder.md
# mbtrain_partner_responder

Responder half of the MBTRAIN sideband handshake. It services the link partner's MBTRAIN substate requests arriving over the sideband RX channel and returns the matching response messages on the sideband TX channel, in the fixed substate order. It sits beside the LTSM MBTRAIN initiator, shares its sideband ports through the LTSM mux, and reports completion, error and timeout to the LTSM top.

## Interface
- TIMEOUT_CYCLES, 800000, per-message wait limit in clk_100MHz cycles (8 ms); legal range 2..2^20-1.
- clk_100MHz  in  1  sideband/LTSM clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; when 0 on a rising edge, all state is cleared.
- enable_i  in  1  LTSM has entered MBTRAIN; 0 forces IDLE.
- SB_RX_msg_i  in  SB_msg_t  received message code.
- SB_RX_dataBus_i  in  64  received message payload.
- SB_RX_msg_valid_i  in  1  RX message present.
- SB_RX_msg_req_o  out  1  responder ready to consume an RX message.
- SB_TX_msg_o  out  SB_msg_t  response message code.
- SB_TX_dataBus_o  out  64  response payload.
- SB_TX_msg_valid_o  out  1  response pending.
- SB_TX_msg_sendNextFlag_i  in  1  sideband TX accepted the pending message.
- substate_o  out  3  current substate index, 0..5.
- done_o  out  1  all substates acknowledged.
- error_o  out  1  protocol error or timeout (sticky until IDLE).
- timeout_o  out  1  error cause was timeout.

## Operation
- Substate order, index 0..5: VALVREF, DATAVREF, SPEEDIDLE, TXSELFCAL, RXCLKCAL, LINKSPEED.
- Each substate expects `MBTRAIN_<SUB>_start_req`, answers with `MBTRAIN_<SUB>_start_resp`, then expects `MBTRAIN_<SUB>_end_req` and answers with `MBTRAIN_<SUB>_end_resp`. All codes are SB_msg_t members.
- Internal phase bit: 0 = expecting start, 1 = expecting end.
- FSM states: IDLE, WAIT_REQ, SEND_RESP, DONE, ERROR.
- IDLE: outputs at reset values. Moves to WAIT_REQ when enable_i=1, with substate=0 and phase=0.
- WAIT_REQ: SB_RX_msg_req_o=1. A message is consumed on a cycle with req_o=1 and SB_RX_msg_valid_i=1.
  - If the consumed code equals the expected request, latch the response code and payload, then go to SEND_RESP.
  - Any other code goes to ERROR with timeout_o=0.
- Payload: SB_TX_dataBus_o=0 for every response except LINKSPEED end_resp, which returns the latched SB_RX_dataBus_i of LINKSPEED end_req.
- SEND_RESP: SB_TX_msg_valid_o=1, and SB_TX_msg_o and SB_TX_dataBus_o are held stable. When SB_TX_msg_sendNextFlag_i=1:
  - After a start_resp: phase←1, go to WAIT_REQ.
  - After an end_resp with substate<5: substate+1, phase←0, go to WAIT_REQ.
  - After an end_resp with substate=5: go to DONE.
- DONE: done_o=1 and stays 1 while enable_i=1. SB_RX_msg_req_o=0, so extra RX messages are not consumed.
- ERROR: error_o=1, no RX consumption, no TX.
- Any state with enable_i=0 moves to IDLE next cycle. Internal registers clear there.
- Timeout counter (20 bits):
  - Clears on entry to WAIT_REQ and SEND_RESP.
  - Increments each cycle spent in those states.
  - When it equals TIMEOUT_CYCLES-1 and no message or flag completes that cycle, go to ERROR with timeout_o=1.
  - Completion takes priority over timeout in the same cycle.
  - Holds 0 in IDLE, DONE and ERROR.
- A partner request that arrives while in SEND_RESP is not consumed, because req_o=0. It is consumed in the next WAIT_REQ.

## Timing
- Reset values (and IDLE values): SB_RX_msg_req_o=0, SB_TX_msg_valid_o=0, SB_TX_msg_o=NOP/default code, SB_TX_dataBus_o=0, substate_o=0, done_o=0, error_o=0, timeout_o=0.
- enable_i rises in cycle E: WAIT_REQ and req_o=1 from E+1.
- Request consumed in cycle N: req_o=0 and SB_TX_msg_valid_o=1 with the response from N+1.
- sendNextFlag_i=1 in cycle M with valid=1: valid=0 and req_o=1 at M+1. Minimum request-to-request spacing is 2 cycles.
- sendNextFlag_i is ignored when valid=0.
- substate_o updates at M+1 after an end_resp flag.
- done_o rises at M+1 after the LINKSPEED end_resp flag.
- reset=0 or enable_i=0 mid-handshake: the pending response is dropped, with valid=0 next cycle. No partial substate is retained.
- error_o and timeout_o assert the cycle after the detecting edge.

## Test plan
- Full train: enable, then feed 12 in-order requests, each with sendNextFlag one cycle after valid. Expect 12 correct responses, substate_o stepping 0→5, done_o=1 one cycle after the 12th flag, and no RX consumption after DONE.
- Backpressure: hold sendNextFlag_i=0 for 50 cycles on VALVREF start_resp. Expect valid, code and data stable for all 50 cycles, and req_o=0 throughout.
- Payload: LINKSPEED end_req payload 0xDEAD_BEEF_0123_4567. Expect end_resp data 0xDEAD_BEEF_0123_4567; all other responses carry 0.
- Protocol error: send DATAVREF start_req while VALVREF end_req is expected. Expect error_o=1, timeout_o=0, and no TX.
- Timeout with TIMEOUT_CYCLES=16: with no request, expect error_o=timeout_o=1 exactly 16 cycles after entering WAIT_REQ. A request on cycle 16 completes normally with no error.
- Abort: drop enable_i while a SPEEDIDLE end_resp is pending. Next cycle expect all outputs at reset values. Re-enable and expect the sequence to restart from VALVREF.
